// File: rtl/tl_a_burst_arbiter.sv
// Round-robin arbiter that shares one TileLink A-channel sink among N_REQ requesters.
// Multi-beat data messages hold the grant until their last beat, and a stalled choice holds until it fires.
module tl_a_burst_arbiter #(
    parameter  int N_REQ       = 2,
    parameter  int BEAT_BYTES  = 8,
    parameter  int MAX_LG_SIZE = 6,
    localparam int SEL_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int DATA_W      = 8 * BEAT_BYTES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        io_in_valid,
    output logic [N_REQ-1:0]        io_in_ready,
    input  logic [3*N_REQ-1:0]      io_in_bits_opcode,
    input  logic [3*N_REQ-1:0]      io_in_bits_param,
    input  logic [4*N_REQ-1:0]      io_in_bits_size,
    input  logic [3*N_REQ-1:0]      io_in_bits_source,
    input  logic [32*N_REQ-1:0]     io_in_bits_address,
    input  logic [BEAT_BYTES*N_REQ-1:0] io_in_bits_mask,
    input  logic [DATA_W*N_REQ-1:0] io_in_bits_data,
    input  logic [N_REQ-1:0]        io_in_bits_corrupt,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [2:0]              io_out_bits_opcode,
    output logic [2:0]              io_out_bits_param,
    output logic [3:0]              io_out_bits_size,
    output logic [2:0]              io_out_bits_source,
    output logic [31:0]             io_out_bits_address,
    output logic [BEAT_BYTES-1:0]   io_out_bits_mask,
    output logic [DATA_W-1:0]       io_out_bits_data,
    output logic                    io_out_bits_corrupt,
    output logic [SEL_W-1:0]        io_out_sel
);

    localparam int LG_BB     = $clog2(BEAT_BYTES);
    localparam int MAX_BEATS = 1 << (MAX_LG_SIZE - LG_BB);
    localparam int CNT_W     = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HELD  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    logic [1:0]       st_q, st_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] beats_left_q, beats_left_d;

    logic [SEL_W-1:0] sel_s;
    logic [SEL_W-1:0] out_sel_s;
    logic [CNT_W-1:0] beats_m1_s;
    logic [3:0]       lg_s;
    logic             fire_s;

    // Lane reached k steps after base, wrapping modulo N_REQ (k in 1..N_REQ).
    function automatic logic [SEL_W-1:0] lane_at(input logic [SEL_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end else begin
            sum = sum;
        end
        return SEL_W'(sum);
    endfunction

    // Lane selection: scan is walked lowest priority first so the nearest valid lane wins.
    always_comb begin
        sel_s = last_q;
        if (st_q == ST_IDLE) begin
            for (int k = N_REQ; k >= 1; k--) begin
                if (io_in_valid[lane_at(last_q, k)]) begin
                    sel_s = lane_at(last_q, k);
                end else begin
                    sel_s = sel_s;
                end
            end
        end else begin
            sel_s = owner_q;
        end
    end

    assign out_sel_s           = reset ? {SEL_W{1'b0}} : sel_s;
    assign io_out_sel          = out_sel_s;
    assign io_out_valid        = ~reset & io_in_valid[out_sel_s];
    assign fire_s              = io_out_valid & io_out_ready;
    assign io_out_bits_opcode  = io_in_bits_opcode [int'(out_sel_s)*3 +: 3];
    assign io_out_bits_param   = io_in_bits_param  [int'(out_sel_s)*3 +: 3];
    assign io_out_bits_size    = io_in_bits_size   [int'(out_sel_s)*4 +: 4];
    assign io_out_bits_source  = io_in_bits_source [int'(out_sel_s)*3 +: 3];
    assign io_out_bits_address = io_in_bits_address[int'(out_sel_s)*32 +: 32];
    assign io_out_bits_mask    = io_in_bits_mask   [int'(out_sel_s)*BEAT_BYTES +: BEAT_BYTES];
    assign io_out_bits_data    = io_in_bits_data   [int'(out_sel_s)*DATA_W +: DATA_W];
    assign io_out_bits_corrupt = io_in_bits_corrupt[out_sel_s];

    // Only the selected lane sees the sink's ready.
    always_comb begin
        io_in_ready = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            io_in_ready[i] = ~reset & io_out_ready & (SEL_W'(i) == out_sel_s);
        end
    end

    // Beats minus one for the presented message; oversize data messages saturate.
    always_comb begin
        lg_s       = 4'd0;
        beats_m1_s = {CNT_W{1'b0}};
        if (!io_out_bits_opcode[2] && (io_out_bits_size > 4'(LG_BB))) begin
            lg_s       = (io_out_bits_size > 4'(MAX_LG_SIZE)) ? 4'(MAX_LG_SIZE) : io_out_bits_size;
            beats_m1_s = CNT_W'((32'd1 << (lg_s - 4'(LG_BB))) - 32'd1);
        end else begin
            beats_m1_s = {CNT_W{1'b0}};
        end
    end

    // Grant-lock state machine.
    always_comb begin
        st_d         = st_q;
        owner_d      = owner_q;
        last_d       = last_q;
        beats_left_d = beats_left_q;
        case (st_q)
            ST_IDLE, ST_HELD: begin
                if (fire_s) begin
                    if (beats_m1_s == {CNT_W{1'b0}}) begin
                        st_d   = ST_IDLE;
                        last_d = sel_s;
                    end else begin
                        st_d         = ST_BURST;
                        owner_d      = sel_s;
                        beats_left_d = beats_m1_s;
                    end
                end else if (io_out_valid && (st_q == ST_IDLE)) begin
                    st_d    = ST_HELD;
                    owner_d = sel_s;
                end else begin
                    st_d = st_q;
                end
            end
            ST_BURST: begin
                if (fire_s) begin
                    if (beats_left_q == CNT_W'(1)) begin
                        st_d         = ST_IDLE;
                        last_d       = owner_q;
                        beats_left_d = {CNT_W{1'b0}};
                    end else begin
                        beats_left_d = beats_left_q - CNT_W'(1);
                    end
                end else begin
                    st_d = st_q;
                end
            end
            default: begin
                st_d         = ST_IDLE;
                beats_left_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers with synchronous reset; lane 0 gets first priority after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q         <= ST_IDLE;
            owner_q      <= {SEL_W{1'b0}};
            last_q       <= SEL_W'(N_REQ - 1);
            beats_left_q <= {CNT_W{1'b0}};
        end else begin
            st_q         <= st_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            beats_left_q <= beats_left_d;
        end
    end

`ifndef SYNTHESIS
    tl_a_burst_arbiter_chk #(
        .MAX_LG_SIZE(MAX_LG_SIZE)
    ) u_chk (
        .clock        (clock),
        .reset        (reset),
        .fire_i       (fire_s),
        .first_beat_i (st_q != ST_BURST),
        .has_data_i   (~io_out_bits_opcode[2]),
        .size_i       (io_out_bits_size)
    );
`endif

endmodule

// Simulation-only checks for the arbiter.
module tl_a_burst_arbiter_chk #(
    parameter int MAX_LG_SIZE = 6
) (
    input logic       clock,
    input logic       reset,
    input logic       fire_i,
    input logic       first_beat_i,
    input logic       has_data_i,
    input logic [3:0] size_i
);

    // Data messages larger than the largest legal size are saturated by the beat counter.
    assert property (@(posedge clock) disable iff (reset)
        (fire_i && first_beat_i && has_data_i) |-> (size_i <= 4'(MAX_LG_SIZE)))
        else $error("tl_a_burst_arbiter: data message size %0d exceeds maximum", size_i);

endmodule
